// File: rtl/aes32_round_sequencer_pkg.sv
// +-----------------------------------------------------------------------+
// | aes32_round_sequencer_pkg: shared state encoding and sizing helpers   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package aes32_round_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int c_NROUNDS_AES128 = 10;
  localparam int c_NROUNDS_AES192 = 12;
  localparam int c_NROUNDS_AES256 = 14;
  localparam int c_NROUNDS_MAX    = 14;

  // A single-round configuration still needs a 1-bit counter register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes32_round_sequencer_phase_ctr.sv
// +-----------------------------------------------------------------------+
// | aes32_round_sequencer_phase_ctr: enabled modulo-PERIOD phase counter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module aes32_round_sequencer_phase_ctr #(
  parameter int PERIOD = 8,
  parameter int WIDTH  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_phase,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      if (r_phase == c_LAST) r_phase <= '0;
      else                   r_phase <= r_phase + 1'b1;
    end
  end

  assign o_phase = r_phase;
  assign o_wrap  = i_en && (r_phase == c_LAST);

endmodule

`default_nettype wire

// File: rtl/aes32_round_sequencer.sv
// +-----------------------------------------------------------------------+
// | aes32_round_sequencer: randomness-gated control FSM for the masked   |
// | 32-bit AES round datapath. Rev 1.0                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

module aes32_round_sequencer
  import aes32_round_sequencer_pkg::*;
#(
  parameter int NROUNDS  = 10,
  parameter int SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  output logic       en_pipe,
  output logic       sel_load,
  output logic [3:0] en_state,
  output logic [1:0] col_idx,
  output logic       sb_issue,
  output logic       last_round,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int c_PERIOD = SBOX_LAT + 4;
  localparam int c_PH_W   = $clog2(c_PERIOD);
  localparam int c_RND_W  = cnt_width(NROUNDS);

  localparam logic [c_RND_W-1:0] c_LAST_RND = c_RND_W'(NROUNDS - 1);
  localparam logic [c_PH_W-1:0]  c_WB_START = c_PH_W'(SBOX_LAT);
  localparam logic [c_PH_W-1:0]  c_ISSUE_END = c_PH_W'(4);

  seq_state_t         r_state;
  logic [c_RND_W-1:0] r_round;

  logic              w_run;
  logic              w_en_pipe;
  logic              w_wrap;
  logic [c_PH_W-1:0] w_phase;
  logic [c_PH_W-1:0] w_wb_off;
  logic              w_issue;
  logic              w_wb;

  assign w_run     = (r_state == ST_RUN);
  assign w_en_pipe = w_run && rnd_valid;

  aes32_round_sequencer_phase_ctr #(
    .PERIOD (c_PERIOD),
    .WIDTH  (c_PH_W)
  ) u_phase_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == ST_LOAD),
    .i_en    (w_en_pipe),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_round <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_round <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_wrap) begin
            if (r_round == c_LAST_RND) r_state <= ST_DONE;
            else                       r_round <= r_round + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
            r_round <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue and writeback windows are decoded independently; they may overlap when SBOX_LAT < 4.
  assign w_issue  = w_run && (w_phase < c_ISSUE_END);
  assign w_wb     = w_en_pipe && (w_phase >= c_WB_START);
  assign w_wb_off = w_phase - c_WB_START;

  always_comb begin
    en_state = 4'h0;
    if (r_state == ST_LOAD) en_state = 4'hF;
    else if (w_wb)          en_state = 4'b0001 << w_wb_off;
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign sel_load   = (r_state == ST_LOAD);
  assign out_valid  = (r_state == ST_DONE);
  assign en_pipe    = w_en_pipe;
  assign rnd_ready  = w_en_pipe;
  assign sb_issue   = w_issue;
  assign col_idx    = w_issue ? w_phase[1:0] : 2'd0;
  assign last_round = w_run && (r_round == c_LAST_RND);
  assign round_idx  = 4'(r_round);

endmodule

`default_nettype wire
